// File: rtl/adsr_manager.sv
// ADSR envelope for one voice: one-hot phase FSM plus an 18-bit saturating volume stepped on new_sample.
// Latency: 1 clk from pulse/tick to state/volume; no backpressure, events are single-cycle strobes.
module adsr_manager (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_sample,
  input  logic        new_note_pulse,
  input  logic        release_note_pulse,
  input  logic [6:0]  attack_rate,
  input  logic [6:0]  decay_rate,
  input  logic [6:0]  release_rate,
  input  logic [6:0]  sustain_value,
  output logic [17:0] volume,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ATTACK  = 5'b00010,
    DECAY   = 5'b00100,
    SUSTAIN = 5'b01000,
    RELEASE = 5'b10000
  } state_e;

  localparam logic [17:0] VOL_MAX = 18'h3FFFF;

  state_e      state_q, state_d;
  logic [17:0] volume_q, volume_d;

  // Largest step is 0x20000, so it always fits in the 18-bit volume width.
  function automatic logic [17:0] step_of(input logic [6:0] r);
    return ({11'd0, r} + 18'd1) << 10;
  endfunction

  logic [17:0] sus_lvl;
  logic [17:0] step_a, step_d, step_r;
  logic [18:0] atk_sum;

  always_comb begin
    sus_lvl = {sustain_value, 11'd0};
    step_a  = step_of(attack_rate);
    step_d  = step_of(decay_rate);
    step_r  = step_of(release_rate);
    atk_sum = {1'b0, volume_q} + {1'b0, step_a};

    state_d  = state_q;
    volume_d = volume_q;

    if (new_note_pulse) begin
      state_d = ATTACK;
    end else if (release_note_pulse &&
                 (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (new_sample) begin
      case (state_q)
        IDLE: begin
          volume_d = '0;
        end
        ATTACK: begin
          if (atk_sum >= {1'b0, VOL_MAX}) begin
            volume_d = VOL_MAX;
            state_d  = DECAY;
          end else begin
            volume_d = atk_sum[17:0];
          end
        end
        DECAY: begin
          // v - step <= S rewritten as v <= S + step to stay unsigned without wrap.
          if ({1'b0, volume_q} <= ({1'b0, sus_lvl} + {1'b0, step_d})) begin
            volume_d = sus_lvl;
            state_d  = SUSTAIN;
          end else begin
            volume_d = volume_q - step_d;
          end
        end
        SUSTAIN: begin
          volume_d = sus_lvl;
        end
        RELEASE: begin
          if (volume_q <= step_r) begin
            volume_d = '0;
            state_d  = IDLE;
          end else begin
            volume_d = volume_q - step_r;
          end
        end
        default: begin
          volume_d = '0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      volume_q <= '0;
    end else begin
      state_q  <= state_d;
      volume_q <= volume_d;
    end
  end

  assign volume = volume_q;
  assign state  = state_q;

endmodule

// File: tb/tb_adsr_manager.sv
// Bench for adsr_manager: vector table, hand sequences for long ramps/retrigger/reset,
// and randomized traffic against an integer phase/volume reference model.
module tb_adsr_manager;

  logic        clk = 1'b0;
  logic        rst, new_sample, new_note_pulse, release_note_pulse;
  logic [6:0]  attack_rate, decay_rate, release_rate, sustain_value;
  logic [17:0] volume;
  logic [4:0]  state;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0..4 = idle, attack, decay, sustain, release.
  int m_phase = 0;
  int m_vol   = 0;

  always #10 clk = ~clk;

  adsr_manager dut (
    .clk                (clk),
    .rst                (rst),
    .new_sample         (new_sample),
    .new_note_pulse     (new_note_pulse),
    .release_note_pulse (release_note_pulse),
    .attack_rate        (attack_rate),
    .decay_rate         (decay_rate),
    .release_rate       (release_rate),
    .sustain_value      (sustain_value),
    .volume             (volume),
    .state              (state)
  );

  typedef struct {
    logic       v_rst, v_ns, v_nn, v_rel;
    logic [6:0] v_ar;
    logic [6:0] v_sv;
    logic [4:0] e_state;
    int         e_vol;
  } vec_t;

  function automatic logic [4:0] onehot(input int p);
    logic [4:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    int s;
    s = int'(sustain_value) * 2048;
    if (rst) begin
      m_phase = 0;
      m_vol   = 0;
    end else if (new_note_pulse) begin
      m_phase = 1;
    end else if (release_note_pulse && m_phase >= 1 && m_phase <= 3) begin
      m_phase = 4;
    end else if (new_sample) begin
      case (m_phase)
        0: m_vol = 0;
        1: begin
          m_vol = m_vol + (int'(attack_rate) + 1) * 1024;
          if (m_vol >= 262143) begin m_vol = 262143; m_phase = 2; end
        end
        2: begin
          m_vol = m_vol - (int'(decay_rate) + 1) * 1024;
          if (m_vol <= s) begin m_vol = s; m_phase = 3; end
        end
        3: m_vol = s;
        default: begin
          m_vol = m_vol - (int'(release_rate) + 1) * 1024;
          if (m_vol <= 0) begin m_vol = 0; m_phase = 0; end
        end
      endcase
    end
  endtask

  // Inputs are set at the falling edge before calling; pulses clear afterwards.
  task automatic cyc(input string nm);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk({nm, " state"}, 32'(state), 32'(onehot(m_phase)));
    chk({nm, " volume"}, 32'(volume), m_vol);
    rst = 0; new_sample = 0; new_note_pulse = 0; release_note_pulse = 0;
  endtask

  task automatic tick(input string nm);
    new_sample = 1;
    cyc(nm);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc("reset");
  endtask

  vec_t vecs[20];

  initial begin
    rst = 1; new_sample = 0; new_note_pulse = 0; release_note_pulse = 0;
    attack_rate = 7'h7F; decay_rate = 7'h7F; release_rate = 7'h7F; sustain_value = 7'h20;
    @(negedge clk);

    // ---------------- table-driven vectors ----------------
    //          rst  ns   nn   rel  ar     sv     state     vol
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,7'h7F,7'h20,5'b00001,0};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,7'h7F,7'h20,5'b00001,0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,7'h7F,7'h20,5'b00001,0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00001,0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,7'h7F,7'h20,5'b00010,0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00010,32'h20000};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,7'h7F,7'h20,5'b00010,32'h20000};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00100,32'h3FFFF};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00100,32'h1FFFF};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b01000,32'h10000};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b01000,32'h10000};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h30,5'b01000,32'h18000};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b1,7'h7F,7'h30,5'b10000,32'h18000};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h30,5'b00001,0};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b1,7'h7F,7'h30,5'b00001,0};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b1,7'h7F,7'h20,5'b00010,0};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0,7'h00,7'h20,5'b00010,32'h400};
    vecs[17] = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00010,32'h20400};
    vecs[18] = '{1'b0,1'b1,1'b1,1'b0,7'h7F,7'h20,5'b00010,32'h20400};
    vecs[19] = '{1'b0,1'b1,1'b0,1'b0,7'h7F,7'h20,5'b00100,32'h3FFFF};

    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].v_rst; new_sample = vecs[i].v_ns;
      new_note_pulse = vecs[i].v_nn; release_note_pulse = vecs[i].v_rel;
      attack_rate = vecs[i].v_ar; sustain_value = vecs[i].v_sv;
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d volume", i), 32'(volume), vecs[i].e_vol);
      rst = 0; new_sample = 0; new_note_pulse = 0; release_note_pulse = 0;
    end

    // Reset in DECAY returns to IDLE/0 on the very next edge.
    rst = 1;
    cyc("rst in decay");
    chk("rst in decay state", 32'(state), 32'h1);
    chk("rst in decay volume", 32'(volume), 0);

    // ---------------- nominal run, tick every 128 clks ----------------
    attack_rate = 7'h7F; sustain_value = 7'h20;
    rst = 1; cyc("nom rst"); rst = 1; cyc("nom rst"); rst = 1; cyc("nom rst");
    for (int t = 0; t < 3; t++) begin
      repeat (127) cyc("nom idle");
      tick("nom idle tick");
    end
    chk("idle after ticks", 32'(volume), 0);
    new_note_pulse = 1; cyc("nom note-on");
    for (int t = 1; t <= 27; t++) begin
      repeat (127) cyc("nom gap");
      tick("nom tick");
      case (t)
        1: chk("t1 vol", 32'(volume), 32'h20000);
        2: begin chk("t2 vol", 32'(volume), 32'h3FFFF); chk("t2 st", 32'(state), 32'h04); end
        3: chk("t3 vol", 32'(volume), 32'h1FFFF);
        4: begin chk("t4 vol", 32'(volume), 32'h10000); chk("t4 st", 32'(state), 32'h08); end
        default: chk("sustain hold", 32'(volume), 32'h10000);
      endcase
    end
    release_note_pulse = 1; cyc("nom note-off");
    chk("note-off st", 32'(state), 32'h10);
    repeat (127) cyc("nom gap");
    tick("nom release tick");
    chk("release end vol", 32'(volume), 0);
    chk("release end st", 32'(state), 32'h01);

    // ---------------- slow attack: 256 ticks of 0x400 ----------------
    do_reset();
    attack_rate = 7'h00;
    new_note_pulse = 1; cyc("slow note-on");
    for (int t = 1; t <= 255; t++) begin
      cyc("slow gap");
      tick("slow tick");
    end
    chk("slow 255 vol", 32'(volume), 32'h3FC00);
    chk("slow 255 st", 32'(state), 32'h02);
    tick("slow tick 256");
    chk("slow 256 vol", 32'(volume), 32'h3FFFF);
    chk("slow 256 st", 32'(state), 32'h04);

    // ---------------- retrigger from RELEASE at 0x8000 ----------------
    do_reset();
    attack_rate = 7'h7F; release_rate = 7'h5F;
    new_note_pulse = 1; cyc("rt note-on");
    tick("rt attack");
    release_note_pulse = 1; cyc("rt note-off");
    tick("rt release");
    chk("rt release vol", 32'(volume), 32'h8000);
    new_note_pulse = 1; new_sample = 1; cyc("rt retrigger");
    chk("rt retrig st", 32'(state), 32'h02);
    chk("rt retrig vol", 32'(volume), 32'h8000);
    attack_rate = 7'h00;
    tick("rt attack from 8000");
    chk("rt resume vol", 32'(volume), 32'h8400);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      rst                = ($urandom_range(0, 299) == 0);
      new_sample         = ($urandom_range(0, 2) == 0);
      new_note_pulse     = ($urandom_range(0, 79) == 0);
      release_note_pulse = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) attack_rate   = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) decay_rate    = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) release_rate  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 31) == 0) sustain_value = 7'($urandom_range(0, 127));
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
